// File: rtl/dot_product_scheduler_if.sv
// Job-in / result-out handshake bundle for the dot-product scheduler.
// master = job source and result consumer, slave = scheduler.
interface dot_product_scheduler_if #(
    parameter int ACC_WIDTH    = 32,
    parameter int JOB_ID_WIDTH = 4
);
    logic                    job_valid;
    logic [JOB_ID_WIDTH-1:0] job_id;
    logic                    job_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [ACC_WIDTH-1:0]    res_data;
    logic [JOB_ID_WIDTH-1:0] res_job_id;

    modport master (
        output job_valid, job_id, res_ready,
        input  job_ready, res_valid, res_data, res_job_id
    );

    modport slave (
        input  job_valid, job_id, res_ready,
        output job_ready, res_valid, res_data, res_job_id
    );
endinterface

// File: rtl/dot_product_scheduler.sv
// Round-robin job dispatcher for NUM_UNITS dot-product units, with per-unit
// result hold registers drained round-robin into a small tagged result FIFO.
module dot_product_scheduler #(
    parameter int NUM_UNITS    = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int JOB_ID_WIDTH = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    dot_product_scheduler_if.slave            bus,
    output logic [NUM_UNITS-1:0]              start_array,
    output logic [NUM_UNITS*JOB_ID_WIDTH-1:0] unit_job_id,
    input  logic [NUM_UNITS-1:0]              done_array,
    input  logic [NUM_UNITS*ACC_WIDTH-1:0]    result_array,
    output logic [NUM_UNITS-1:0]              busy_array,
    output logic                              idle,
    output logic                              err_spurious
);
    localparam int UW = $clog2(NUM_UNITS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int EW = ACC_WIDTH + JOB_ID_WIDTH;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } unit_state_e;

    unit_state_e             state_q   [NUM_UNITS];
    logic [JOB_ID_WIDTH-1:0] unit_id_q [NUM_UNITS];
    logic [ACC_WIDTH-1:0]    hold_q    [NUM_UNITS];
    logic [NUM_UNITS-1:0]    start_q;
    logic [UW-1:0]           rr_disp_q;
    logic [UW-1:0]           rr_drain_q;
    logic                    err_q;

    logic [EW-1:0]           fifo_q    [FIFO_DEPTH];
    logic [FW-1:0]           wptr_q;
    logic [FW-1:0]           rptr_q;
    logic [CW-1:0]           count_q;

    logic                    grant_found_s;
    logic [UW-1:0]           grant_idx_s;
    logic                    drain_found_s;
    logic [UW-1:0]           drain_idx_s;
    logic                    accept_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [EW-1:0]           head_s;

    // First FREE unit at/after rr_disp and first HOLD unit at/after rr_drain.
    always_comb begin
        logic [UW-1:0] cand;
        cand          = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        drain_found_s = 1'b0;
        drain_idx_s   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = rr_disp_q + UW'(k);
            if (!grant_found_s && (state_q[cand] == FREE)) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_found_s = grant_found_s;
            end
            cand = rr_drain_q + UW'(k);
            if (!drain_found_s && (state_q[cand] == HOLD)) begin
                drain_found_s = 1'b1;
                drain_idx_s   = cand;
            end else begin
                drain_found_s = drain_found_s;
            end
        end
    end

    assign fifo_empty_s = (count_q == CW'(0));
    assign fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
    assign accept_s     = bus.job_valid && grant_found_s;
    assign pop_s        = !fifo_empty_s && bus.res_ready;
    // A full FIFO still takes a push when its head leaves on the same edge.
    assign push_s       = drain_found_s && (!fifo_full_s || pop_s);

    // Per-unit FSMs, round-robin pointers, start pulses and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i]   <= FREE;
                unit_id_q[i] <= '0;
                hold_q[i]    <= '0;
            end
            start_q    <= '0;
            rr_disp_q  <= '0;
            rr_drain_q <= '0;
            err_q      <= 1'b0;
        end else begin
            start_q <= '0;
            if (accept_s) begin
                state_q[grant_idx_s]   <= BUSY;
                unit_id_q[grant_idx_s] <= bus.job_id;
                start_q[grant_idx_s]   <= 1'b1;
                rr_disp_q              <= grant_idx_s + UW'(1);
            end else begin
                rr_disp_q <= rr_disp_q;
            end
            // A done in the start-pulse cycle cannot belong to this job.
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (done_array[i]) begin
                    if ((state_q[i] == BUSY) && !start_q[i]) begin
                        state_q[i] <= HOLD;
                        hold_q[i]  <= result_array[i*ACC_WIDTH +: ACC_WIDTH];
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    hold_q[i] <= hold_q[i];
                end
            end
            if (push_s) begin
                state_q[drain_idx_s] <= FREE;
                rr_drain_q           <= drain_idx_s + UW'(1);
            end else begin
                rr_drain_q <= rr_drain_q;
            end
        end
    end

    // Result FIFO storage and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_s) begin
                fifo_q[wptr_q] <= {hold_q[drain_idx_s], unit_id_q[drain_idx_s]};
                wptr_q         <= wptr_q + FW'(1);
            end else begin
                wptr_q <= wptr_q;
            end
            if (pop_s) begin
                rptr_q <= rptr_q + FW'(1);
            end else begin
                rptr_q <= rptr_q;
            end
            if (push_s && !pop_s) begin
                count_q <= count_q + CW'(1);
            end else if (pop_s && !push_s) begin
                count_q <= count_q - CW'(1);
            end else begin
                count_q <= count_q;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        unit_job_id = '0;
        busy_array  = '0;
        idle        = fifo_empty_s;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_job_id[i*JOB_ID_WIDTH +: JOB_ID_WIDTH] = unit_id_q[i];
            busy_array[i] = (state_q[i] != FREE);
            if (state_q[i] != FREE) begin
                idle = 1'b0;
            end else begin
                idle = idle;
            end
        end
    end

    assign head_s         = fifo_q[rptr_q];
    assign start_array    = start_q;
    assign err_spurious   = err_q;
    assign bus.job_ready  = grant_found_s;
    assign bus.res_valid  = !fifo_empty_s;
    assign bus.res_data   = head_s[EW-1:JOB_ID_WIDTH];
    assign bus.res_job_id = head_s[JOB_ID_WIDTH-1:0];
endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed self-checking bench for dot_product_scheduler (4 units, 4-deep FIFO).
module tb_dot_product_scheduler;
    logic        clk;
    logic        reset_n;
    logic [3:0]  start_array;
    logic [15:0] unit_job_id;
    logic [3:0]  done_array;
    logic [127:0] result_array;
    logic [3:0]  busy_array;
    logic        idle;
    logic        err_spurious;
    int          n_cmp;
    int          n_fail;

    dot_product_scheduler_if #(.ACC_WIDTH(32), .JOB_ID_WIDTH(4)) bif ();

    dot_product_scheduler #(
        .NUM_UNITS(4), .ACC_WIDTH(32), .JOB_ID_WIDTH(4), .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bif.slave),
        .start_array  (start_array),
        .unit_job_id  (unit_job_id),
        .done_array   (done_array),
        .result_array (result_array),
        .busy_array   (busy_array),
        .idle         (idle),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bif.job_valid = 1'b0;
        bif.res_ready = 1'b0;
        done_array    = 4'b0000;
        reset_n       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset_n        = 1'b1;
        bif.job_valid  = 1'b0;
        bif.job_id     = 4'd0;
        bif.res_ready  = 1'b0;
        done_array     = 4'b0000;
        result_array   = 128'd0;

        // Reset asserted mid-cycle, outputs take reset values immediately
        #3 reset_n = 1'b0;
        #1;
        chk("rst_idle", idle, 1'b1);
        chk("rst_job_ready", bif.job_ready, 1'b1);
        chk("rst_res_valid", bif.res_valid, 1'b0);
        chk("rst_start", start_array, 4'b0000);
        chk("rst_busy", busy_array, 4'b0000);
        chk("rst_err", err_spurious, 1'b0);
        chk("rst_uid", unit_job_id, 16'h0000);
        step();
        step();
        reset_n = 1'b1;

        // Round-robin dispatch of ids 1..4, id 5 held off
        bif.job_valid = 1'b1;
        bif.job_id = 4'd1;
        step();
        chk("rr_start0", start_array, 4'b0001);
        bif.job_id = 4'd2;
        step();
        chk("rr_start1", start_array, 4'b0010);
        bif.job_id = 4'd3;
        step();
        chk("rr_start2", start_array, 4'b0100);
        bif.job_id = 4'd4;
        step();
        chk("rr_start3", start_array, 4'b1000);
        chk("rr_ready_low", bif.job_ready, 1'b0);
        bif.job_id = 4'd5;
        step();
        chk("rr_held_start", start_array, 4'b0000);
        chk("rr_held_ready", bif.job_ready, 1'b0);
        chk("rr_uid", unit_job_id, 16'h4321);
        chk("rr_busy", busy_array, 4'b1111);
        chk("rr_not_idle", idle, 1'b0);
        bif.job_valid = 1'b0;

        // Single job id 7 to unit 0, result 0x1234
        do_reset();
        bif.job_valid = 1'b1;
        bif.job_id = 4'd7;
        step();
        bif.job_valid = 1'b0;
        chk("sj_start", start_array, 4'b0001);
        step();
        step();
        done_array = 4'b0001;
        result_array = {32'd0, 32'd0, 32'd0, 32'h0000_1234};
        step();
        done_array = 4'b0000;
        chk("sj_no_res_yet", bif.res_valid, 1'b0);
        chk("sj_hold_busy", busy_array, 4'b0001);
        step();
        chk("sj_res_valid", bif.res_valid, 1'b1);
        chk("sj_res_data", bif.res_data, 32'h0000_1234);
        chk("sj_res_id", bif.res_job_id, 4'd7);
        chk("sj_freed", busy_array, 4'b0000);
        chk("sj_not_idle", idle, 1'b0);
        bif.res_ready = 1'b1;
        bif.job_valid = 1'b1;
        bif.job_id = 4'd9;
        step();
        chk("sj_next_rr", start_array, 4'b0010);
        chk("sj_popped", bif.res_valid, 1'b0);
        bif.job_id = 4'd10;
        step();
        bif.job_id = 4'd11;
        step();
        chk("sj_start3", start_array, 4'b1000);
        bif.job_id = 4'd12;
        step();
        bif.job_valid = 1'b0;
        chk("sj_regrant_u0", start_array, 4'b0001);
        chk("sj_regrant_uid", unit_job_id, 16'hBA9C);
        chk("sj_full_ready", bif.job_ready, 1'b0);

        // Simultaneous done on all units, drained in unit order
        do_reset();
        bif.res_ready = 1'b1;
        bif.job_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bif.job_id = 4'(i);
            step();
        end
        bif.job_valid = 1'b0;
        step();
        done_array = 4'b1111;
        result_array = {32'd40, 32'd30, 32'd20, 32'd10};
        step();
        done_array = 4'b0000;
        chk("sd_hold", busy_array, 4'b1111);
        step();
        chk("sd_d0", bif.res_data, 32'd10);
        chk("sd_i0", bif.res_job_id, 4'd1);
        step();
        chk("sd_d1", bif.res_data, 32'd20);
        step();
        chk("sd_d2", bif.res_data, 32'd30);
        step();
        chk("sd_d3", bif.res_data, 32'd40);
        chk("sd_i3", bif.res_job_id, 4'd4);
        chk("sd_v3", bif.res_valid, 1'b1);
        step();
        chk("sd_empty", bif.res_valid, 1'b0);
        chk("sd_idle", idle, 1'b1);
        chk("sd_no_err", err_spurious, 1'b0);

        // Back-pressure: 5 results, FIFO holds 4, one unit left in HOLD
        do_reset();
        bif.job_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bif.job_id = 4'(i);
            step();
        end
        bif.job_valid = 1'b0;
        step();
        done_array = 4'b1111;
        result_array = {32'd400, 32'd300, 32'd200, 32'd100};
        step();
        done_array = 4'b0000;
        step();
        step();
        step();
        step();
        chk("bp_all_free", busy_array, 4'b0000);
        bif.job_valid = 1'b1;
        bif.job_id = 4'd5;
        step();
        bif.job_valid = 1'b0;
        chk("bp_j5_start", start_array, 4'b0001);
        step();
        done_array = 4'b0001;
        result_array = {32'd0, 32'd0, 32'd0, 32'd500};
        step();
        done_array = 4'b0000;
        step();
        chk("bp_stuck_hold", busy_array, 4'b0001);
        chk("bp_ready", bif.job_ready, 1'b1);
        chk("bp_head", bif.res_data, 32'd100);
        chk("bp_head_id", bif.res_job_id, 4'd1);
        bif.res_ready = 1'b1;
        step();
        chk("bp_d1", bif.res_data, 32'd200);
        chk("bp_hold_drained", busy_array, 4'b0000);
        step();
        chk("bp_d2", bif.res_data, 32'd300);
        step();
        chk("bp_d3", bif.res_data, 32'd400);
        step();
        chk("bp_d4", bif.res_data, 32'd500);
        chk("bp_i4", bif.res_job_id, 4'd5);
        step();
        chk("bp_empty", bif.res_valid, 1'b0);
        chk("bp_idle", idle, 1'b1);

        // Spurious done on a FREE unit
        do_reset();
        done_array = 4'b0010;
        step();
        done_array = 4'b0000;
        chk("sp_err", err_spurious, 1'b1);
        chk("sp_fifo", bif.res_valid, 1'b0);
        chk("sp_busy", busy_array, 4'b0000);
        step();
        chk("sp_sticky", err_spurious, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("sp_rst_clear", err_spurious, 1'b0);
        step();
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_product_scheduler.md
Name: dot_product_scheduler

Overview:
- Sits between the job source (memory controller / host sequencer) and the array of NUM_UNITS dot-product units.
- Accepts job tags over a valid/ready handshake and dispatches each to a free unit, chosen round-robin, with a one-cycle start pulse.
- Captures each unit's result on done and drains results, tagged with their job id, through a small result FIFO.

Parameters:
- NUM_UNITS, 4, number of dot-product units scheduled (power of two, >=2)
- ACC_WIDTH, 32, width of a unit result
- JOB_ID_WIDTH, 4, width of job tag
- FIFO_DEPTH, 4, result FIFO entries (power of two)

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- job_valid  input  1  job offered
- job_id  input  JOB_ID_WIDTH  tag of offered job
- job_ready  output  1  scheduler can accept a job this cycle
- start_array  output  NUM_UNITS  one-cycle start pulse per unit
- unit_job_id  output  NUM_UNITS x JOB_ID_WIDTH  tag held for each unit while busy
- done_array  input  NUM_UNITS  unit finished; result_array valid the same cycle
- result_array  input  NUM_UNITS x ACC_WIDTH  unit results
- res_valid  output  1  FIFO head valid
- res_ready  input  1  consumer takes head
- res_data  output  ACC_WIDTH  head result
- res_job_id  output  JOB_ID_WIDTH  head tag
- busy_array  output  NUM_UNITS  unit is in BUSY or HOLD
- idle  output  1  all units FREE and FIFO empty
- err_spurious  output  1  sticky: done seen on a non-BUSY unit

Behaviour:
- Reset (async assert, sync release): all units FREE, rr_dispatch=0, rr_drain=0, FIFO empty. start_array=0, unit_job_id=0, busy_array=0, res_valid=0, err_spurious=0, idle=1, job_ready=1. Reset mid-operation discards in-flight jobs and FIFO contents.
- Per-unit FSM states: FREE -> BUSY -> HOLD -> FREE.
- job_ready (combinational from registered state) = at least one unit FREE.
- Dispatch: on an edge with job_valid && job_ready, grant the first FREE unit at or after rr_dispatch, searching cyclically.
  - Granted unit: FREE->BUSY, unit_job_id[g] <= job_id.
  - start_array[g] is high for exactly the following cycle.
  - rr_dispatch <= (g+1) mod NUM_UNITS.
  - At most one dispatch per cycle.
- Done: done_array[i] is sampled only when unit i is BUSY. On that edge, capture result_array[i] into a per-unit hold register and move BUSY->HOLD.
  - done on a FREE or HOLD unit, or during its start cycle, is ignored and sets err_spurious.
- Drain: on each edge where the FIFO is not full, or is full and popping this edge (simultaneous push/pop allowed), push one HOLD unit into the FIFO.
  - Unit chosen is the first HOLD unit at or after rr_drain; rr_drain <= (h+1) mod NUM_UNITS.
  - Pushed entry = {hold result, unit_job_id}. Unit HOLD->FREE on that edge.
- Reuse: a unit freed at edge E is visible as FREE after E and can be granted at edge E+1 at the earliest. Dispatch and drain of the same unit never coincide.
- Latency:
  - Job accepted at edge N -> start high in cycle N..N+1.
  - done sampled at edge M -> push at edge M+1 if FIFO has room -> res_valid after M+1.
  - Minimum done-to-res_valid latency is 2 edges.
- FIFO: pop on res_valid && res_ready. res_data and res_job_id are stable while res_valid && !res_ready.
- Back-pressure: FIFO full and no pop -> units stay in HOLD. All units BUSY/HOLD -> job_ready=0.
- busy_array[i] = (state != FREE). idle = all FREE && FIFO empty.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> idle=1, job_ready=1, res_valid=0 immediately; all outputs at reset values.
- Round-robin dispatch: offer ids 1,2,3,4 back-to-back, no done.
  - Required: start_array = 0001, 0010, 0100, 1000 on successive cycles, unit_job_id = 1,2,3,4.
  - job_ready=0 after the fourth accept; id 5 is held off.
- Single job: id 7 to unit 0; done_array=0001 with result 0x0000_1234 three cycles later.
  - Required: res_valid two edges after done, res_data=0x1234, res_job_id=7.
  - Unit 0 is re-grantable one edge after the push.
- Simultaneous done: units 0–3 all done in the same cycle with results 10,20,30,40, res_ready=1.
  - Required: FIFO outputs 10,20,30,40 in unit order on consecutive cycles (rr_drain from 0).
- Back-pressure: res_ready=0, 5 jobs complete.
  - Required: FIFO holds 4, one unit remains in HOLD, job_ready reflects free units.
  - Raise res_ready -> all 5 results drain in order, with no loss or duplication.
- Spurious done: done_array=0010 while unit 1 is FREE -> err_spurious=1 and stays set; FIFO is unaffected. reset_n low clears err_spurious.
